btnscan: RTL
============

# btnscan

Matrix button scanner for the badge SoC: the input-side counterpart of the multiplexed LED driver. Drives one matrix row at a time, samples the column sense lines at the end of each row phase, debounces every key independently, and exposes debounced key state plus sticky change flags and an interrupt to the CPU-side register block.

## Interface

Parameters:
- ROWS, 3, number of matrix rows (driven lines)
- COLS, 3, number of column sense lines
- SETTLE, 85, cycles each row is driven before it is sampled; legal range 4..2047
- DEB, 4, consecutive differing samples required to flip a key; legal range 1..15

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- rowsel  out  ROWS  one-hot row drive, active-high, registered
- colin  in  COLS  raw column sense, active-high = closed key on the driven row; asynchronous
- btn  out  ROWS*COLS  debounced key state; key (r,c) is bit r*COLS+c
- chg  out  ROWS*COLS  sticky flags: bit set when the matching btn bit flips
- ack  in  1  single-cycle pulse; clears all chg bits
- irq  out  1  |chg, combinational from chg registers

## Operation

- colin passes through a 2-flop synchronizer (reset value 0) before use.
- Phase counter ctr counts 0..SETTLE-1 per row; at SETTLE-1 it wraps to 0 and rowsel rotates one position left, ROWS-1 wraps to row 0.
- Sample point: cycle with ctr==SETTLE-1. The synchronized colin is sampled for each key c of the current row r.
- Per-key debounce counter cnt (4 bits):
  - sample == btn bit: cnt <= 0.
  - sample != btn bit and cnt < DEB-1: cnt <= cnt+1.
  - sample != btn bit and cnt == DEB-1: btn bit flips, chg bit sets, cnt <= 0.
- Keys are only updated at their own row's sample point; other keys hold.
- ack clears chg. If a flip and ack occur in the same cycle, the newly flipped bit is set after that edge; all other bits clear.
- Reset (any time, including mid-phase): rowsel=1 (row 0), ctr=0, btn=0, chg=0, all cnt=0, synchronizer=0; irq=0. Scan restarts at row 0 phase cycle 0 on the first cycle after rst deasserts.

## Timing

- Scan period: ROWS*SETTLE cycles (255 at defaults). Row r is sampled at cycle r*SETTLE+SETTLE-1 of each period, counted from the first cycle after reset.
- colin must be stable for at least the 3 cycles preceding the sample point (2 synchronizer stages plus sample register).
- Press/release latency: btn and chg update on the clock edge at the DEB-th consecutive differing sample point; irq rises in the same cycle as chg.
- rowsel changes on the edge following the sample point; rows never overlap, and no cycle has rowsel==0 outside reset.
- ack takes effect on the next edge; irq falls one cycle after ack unless a flip coincides.

## Structure

- Shared header (badge I/O defines): default ROWS, COLS, SETTLE so the LED driver and btnscan stay in phase on shared matrix lines.
- One sub-module, btn_debounce: per-key cnt/state/flip logic with inputs sample, sample_en and outputs state, flip. Instantiated ROWS*COLS times in a generate loop; the top level holds ctr, rowsel, synchronizer, chg and irq.

## Test plan

Defaults ROWS=3, COLS=3, SETTLE=85, DEB=4:
- Reset/scan: rst high 3 cycles, then release -> rowsel=001, btn=0, chg=0, irq=0; rowsel becomes 010 at cycle 85, 100 at 170, 001 at 255.
- Press: colin[2]=1 only while rowsel==010, held -> btn[5] rises at 4th row-1 sample (cycle 4*255-1-85=934 after release... exactly cycle 85+84+3*255=934); chg=0x020, irq=1; all other bits 0.
- Bounce: key bit 0 closed on alternate scans for 10 scans -> btn[0], chg[0] stay 0; cnt never exceeds 1.
- Ack collision: chg=0x020, ack pulsed on the same edge key bit 3 flips -> chg=0x008, irq remains 1; next ack -> chg=0, irq=0 one cycle later.
- Wrap and release: key bit 6 pressed then released -> flips at row-2 sample cycle 254 of its period; chg set for both press and release, btn[6] returns to 0 after 4 open scans.
- Reset mid-operation: btn[5]=1, rst asserted at ctr=40 of row 2 -> next edge btn=0, chg=0, irq=0, rowsel=001, ctr=0.

Source files
------------

// File: rtl/btnscan_pkg.sv
// Shared badge I/O defaults for the matrix scanner. These match the LED driver
// so both blocks stay in phase on the shared matrix lines.
`default_nettype none

package btnscan_pkg;

  localparam int ROWS_DEF   = 3;
  localparam int COLS_DEF   = 3;
  localparam int SETTLE_DEF = 85;
  localparam int DEB_DEF    = 4;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] deb_cnt_t;

  function automatic int ctr_width(input int settle);
    return (settle > 2) ? $clog2(settle) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// Per-key debouncer: the key flips after DEB consecutive enabled samples that
// differ from the current state.
`default_nettype none

module btn_debounce
  import btnscan_pkg::*;
#(
  parameter int DEB = DEB_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic sample_en,
  output logic state,
  output logic flip
);

  deb_cnt_t cnt;
  logic     differ;

  assign differ = sample != state;
  assign flip   = sample_en && differ && (cnt == deb_cnt_t'(DEB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sample_en) begin
      // Any agreeing sample restarts the run, as does the flip itself.
      if (!differ || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (flip) begin
        state <= ~state;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/btnscan.sv
// Matrix button scanner: rotates a one-hot row drive, samples synchronized
// column lines at the end of each row phase and debounces every key.
`default_nettype none

module btnscan
  import btnscan_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int DEB    = DEB_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROWS-1:0]      rowsel,
  input  logic [COLS-1:0]      colin,
  output logic [ROWS*COLS-1:0] btn,
  output logic [ROWS*COLS-1:0] chg,
  input  logic                 ack,
  output logic                 irq
);

  localparam int CTR_W = ctr_width(SETTLE);

  logic [CTR_W-1:0]     ctr;
  logic [COLS-1:0]      sync1;
  logic [COLS-1:0]      sync2;
  logic                 sample_pt;
  logic [ROWS:0]        rot;
  logic [ROWS*COLS-1:0] flip;

  assign sample_pt = ctr == CTR_W'(SETTLE - 1);
  // Low ROWS bits are the left rotation; also degenerates correctly for ROWS==1.
  assign rot       = {rowsel, rowsel[ROWS-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr    <= '0;
      rowsel <= ROWS'(1);
      sync1  <= '0;
      sync2  <= '0;
      chg    <= '0;
    end else begin
      sync1 <= colin;
      sync2 <= sync1;
      // A flip on the ack edge survives the clear.
      chg   <= (ack ? '0 : chg) | flip;
      if (sample_pt) begin
        ctr    <= '0;
        rowsel <= rot[ROWS-1:0];
      end else begin
        ctr <= ctr + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      btn_debounce #(
        .DEB(DEB)
      ) u_deb (
        .clk      (clk),
        .rst      (rst),
        .sample   (sync2[c]),
        .sample_en(sample_pt && rowsel[r]),
        .state    (btn[r*COLS+c]),
        .flip     (flip[r*COLS+c])
      );
    end
  end

  assign irq = |chg;

endmodule

`default_nettype wire
